uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver; the receive end of the uart_tx link. Frame is 1 start bit (0),
//  8 data bits MSB first (bit 7 first), 1 stop bit (1), each CLOCKS_PER_BIT clocks long.

---
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8 data bits MSB first, mid-bit sampling, valid/ack handshake
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 20
) (
    input  logic       rx_clk,
    input  logic       rst_n,
    input  logic       serial_data,
    input  logic       rx_ack,
    output logic [7:0] rx_parallel_data,
    output logic       rx_valid,
    output logic       rx_done,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] rx_state,
    output logic [2:0] bit_index
);

    typedef enum logic [2:0] {
        DATA_IDLE  = 3'd0,
        DATA_START = 3'd1,
        DATA_BIT   = 3'd2,
        DATA_STOP  = 3'd3
    } state_t;

    localparam logic [7:0] HALF_COUNT = 8'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST_COUNT = 8'(CLOCKS_PER_BIT - 1);

    state_t     state;
    logic [7:0] clk_count;
    logic [7:0] shift_reg;
    logic       rx_meta;
    logic       rx_s;

    assign rx_state = state;
    assign busy     = (state != DATA_IDLE);

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_data;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= DATA_IDLE;
            clk_count        <= 8'd0;
            bit_index        <= 3'd7;
            shift_reg        <= 8'd0;
            rx_parallel_data <= 8'd0;
            rx_valid         <= 1'b0;
            rx_done          <= 1'b0;
            frame_err        <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            case (state)
                DATA_IDLE: begin
                    clk_count <= 8'd0;
                    bit_index <= 3'd7;
                    if (!rx_s) begin
                        state <= DATA_START;
                    end
                end

                // A line that is high again at half a bit was a glitch, not a start bit
                DATA_START: begin
                    if (clk_count == HALF_COUNT) begin
                        clk_count <= 8'd0;
                        state     <= rx_s ? DATA_IDLE : DATA_BIT;
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                DATA_BIT: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count            <= 8'd0;
                        shift_reg[bit_index] <= rx_s;
                        if (bit_index == 3'd0) begin
                            bit_index <= 3'd7;
                            state     <= DATA_STOP;
                        end else begin
                            bit_index <= bit_index - 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                // Leaving at mid stop bit gives half a bit of slack for the next start edge
                DATA_STOP: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count <= 8'd0;
                        state     <= DATA_IDLE;
                        if (rx_s) begin
                            rx_parallel_data <= shift_reg;
                            rx_valid         <= 1'b1;
                            rx_done          <= 1'b1;
                            overrun          <= rx_valid && !rx_ack;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                default: begin
                    state     <= DATA_IDLE;
                    clk_count <= 8'd0;
                    bit_index <= 3'd7;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and random frames against a byte-level receiver model
module tb_uart_rx;
    localparam int CPB = 20;

    logic       rx_clk      = 1'b0;
    logic       rst_n       = 1'b0;
    logic       serial_data = 1'b1;
    logic       rx_ack      = 1'b0;
    logic [7:0] rx_parallel_data;
    logic       rx_valid;
    logic       rx_done;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] rx_state;
    logic [2:0] bit_index;

    always #5 rx_clk = ~rx_clk;

    uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .rx_clk           (rx_clk),
        .rst_n            (rst_n),
        .serial_data      (serial_data),
        .rx_ack           (rx_ack),
        .rx_parallel_data (rx_parallel_data),
        .rx_valid         (rx_valid),
        .rx_done          (rx_done),
        .frame_err        (frame_err),
        .overrun          (overrun),
        .busy             (busy),
        .rx_state         (rx_state),
        .bit_index        (bit_index)
    );

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int clash_cnt = 0;

    bit         m_valid = 1'b0;
    logic [7:0] m_data = 8'd0;

    always @(negedge rx_clk) begin
        if (rx_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (frame_err === 1'b1 && (rx_done === 1'b1 || overrun === 1'b1)) clash_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge rx_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        serial_data = 1'b0;
        wait_clk(CPB);
        for (int i = 7; i >= 0; i--) begin
            serial_data = b[i];
            wait_clk(CPB);
        end
        serial_data = stop;
        wait_clk(CPB);
        serial_data = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit stop, input bit ack);
        int d0;
        int f0;
        int o0;
        bit exp_ovr;
        d0 = done_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_frame(b, stop);
        exp_ovr = stop && m_valid;
        if (stop) begin
            m_data  = b;
            m_valid = 1'b1;
        end
        check("done_pulses", done_cnt - d0, {31'd0, stop});
        check("frame_err_pulses", ferr_cnt - f0, {31'd0, !stop});
        check("overrun_pulses", ovr_cnt - o0, {31'd0, exp_ovr});
        check("rx_data", rx_parallel_data, m_data);
        check("rx_valid", rx_valid, m_valid);
        // Let a false start caused by a low stop bit time out before the next frame
        if (!stop) wait_clk(2 * CPB);
        if (ack) begin
            rx_ack = 1'b1;
            wait_clk(1);
            rx_ack  = 1'b0;
            m_valid = 1'b0;
            check("valid_after_ack", rx_valid, 1'b0);
        end
    endtask

    initial begin
        int f0;
        int d0;
        logic [7:0] rb;

        wait_clk(3);
        check("reset_state", rx_state, 3'd0);
        check("reset_bit_index", bit_index, 3'd7);
        check("reset_data", rx_parallel_data, 8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", rx_done, 1'b0);
        rst_n = 1'b1;
        wait_clk(5);

        run_frame(8'hA5, 1'b1, 1'b1);
        run_frame(8'h00, 1'b1, 1'b1);
        run_frame(8'hFF, 1'b1, 1'b1);
        run_frame(8'h3C, 1'b1, 1'b1);
        run_frame(8'h5A, 1'b0, 1'b0);

        f0 = ferr_cnt;
        d0 = done_cnt;
        serial_data = 1'b0;
        wait_clk(5);
        check("glitch_state_start", rx_state, 3'd1);
        check("glitch_busy", busy, 1'b1);
        serial_data = 1'b1;
        wait_clk(15);
        check("glitch_state_idle", rx_state, 3'd0);
        check("glitch_busy_drop", busy, 1'b0);
        check("glitch_no_flags", (ferr_cnt - f0) + (done_cnt - d0), 32'd0);

        run_frame(8'h11, 1'b1, 1'b0);
        run_frame(8'h22, 1'b1, 1'b1);

        f0 = ferr_cnt;
        d0 = done_cnt;
        serial_data = 1'b0;
        wait_clk(390);
        serial_data = 1'b1;
        wait_clk(30);
        check("break_frame_errs", ferr_cnt - f0, 32'd2);
        check("break_no_done", done_cnt - d0, 32'd0);
        check("break_state_idle", rx_state, 3'd0);
        check("break_valid", rx_valid, m_valid);

        rb = 8'hC3;
        serial_data = 1'b0;
        wait_clk(CPB);
        for (int i = 7; i >= 5; i--) begin
            serial_data = rb[i];
            wait_clk(CPB);
        end
        serial_data = rb[4];
        wait_clk(10);
        check("midframe_state", rx_state, 3'd2);
        check("midframe_bit_index", bit_index, 3'd4);
        d0 = done_cnt;
        rst_n = 1'b0;
        wait_clk(2);
        check("abort_state", rx_state, 3'd0);
        check("abort_bit_index", bit_index, 3'd7);
        check("abort_busy", busy, 1'b0);
        check("abort_data", rx_parallel_data, 8'h00);
        m_valid = 1'b0;
        m_data  = 8'h00;
        serial_data = 1'b1;
        rst_n = 1'b1;
        wait_clk(5);
        check("abort_no_done", done_cnt - d0, 32'd0);
        run_frame(8'h81, 1'b1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom);
            run_frame(rb, $urandom_range(3) != 0, 1'($urandom_range(1)));
        end

        check("flag_clash_cycles", clash_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
